// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl: neuron/input walker for the shared dense-layer MAC datapath.
// Emits bias-load, MAC and result-write strobes with their addresses; all
// outputs are registered and zero whenever their strobe is low.
// Optional busy-cycle counter enabled by defining DENSE_SEQ_PERF_EN.
module dense_seq_ctrl #(
    parameter int unsigned IW      = 6,
    parameter int unsigned WAW     = 11,
    parameter int unsigned MAC_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [IW-1:0]  nb_input,
    input  logic [IW-1:0]  nb_neurons,
    input  logic [IW-1:0]  stride,
    input  logic           out_ready,
    output logic           busy,
    output logic           done,
    output logic [IW-1:0]  b_addr,
    output logic           acc_load,
    output logic           mac_en,
    output logic [WAW-1:0] w_addr,
    output logic [IW-1:0]  x_addr,
    output logic           out_wr,
    output logic [IW-1:0]  out_addr,
    output logic [15:0]    perf_cycles
);

    localparam int unsigned CW = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_WRITE, S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  nin_q, nin_d, nn_q, nn_d, stride_q, stride_d;
    logic [IW-1:0]  i_q, i_d, j_q, j_d;
    logic [WAW-1:0] wa_q, wa_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           busy_q, busy_d, done_q, done_d;
    logic           acc_load_q, acc_load_d, mac_en_q, mac_en_d, out_wr_q, out_wr_d;
    logic [IW-1:0]  b_addr_q, b_addr_d, x_addr_q, x_addr_d, out_addr_q, out_addr_d;
    logic [WAW-1:0] w_addr_q, w_addr_d;

    // Next-state, index/address walking and next-cycle output values.
    always_comb begin
        state_d  = state_q;
        nin_d    = nin_q;
        nn_d     = nn_q;
        stride_d = stride_q;
        i_d      = i_q;
        j_d      = j_q;
        wa_d     = wa_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nin_d    = nb_input;
                    nn_d     = nb_neurons;
                    stride_d = stride;
                    i_d      = '0;
                    state_d  = (nb_neurons == '0) ? S_DONE : S_BIAS;
                end
            end
            S_BIAS: begin
                j_d  = '0;
                wa_d = WAW'(i_q);
                if (nin_q == '0) begin
                    cnt_d   = CW'(MAC_LAT - 1);
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (j_q == nin_q - IW'(1)) begin
                    cnt_d   = CW'(MAC_LAT - 1);
                    state_d = S_DRAIN;
                end else begin
                    j_d  = j_q + IW'(1);
                    wa_d = wa_q + WAW'(stride_q);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) state_d = S_WRITE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_WRITE: begin
                if (out_ready) begin
                    if (i_q == nn_q - IW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + IW'(1);
                        state_d = S_BIAS;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d == S_BIAS) || (state_d == S_MAC) ||
                     (state_d == S_DRAIN) || (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        acc_load_d = (state_d == S_BIAS);
        mac_en_d   = (state_d == S_MAC);
        out_wr_d   = (state_d == S_WRITE);
        b_addr_d   = acc_load_d ? i_d  : '0;
        w_addr_d   = mac_en_d   ? wa_d : '0;
        x_addr_d   = mac_en_d   ? j_d  : '0;
        out_addr_d = out_wr_d   ? i_d  : '0;
    end

    // State, shape latch and walking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            nin_q    <= '0;
            nn_q     <= '0;
            stride_q <= '0;
            i_q      <= '0;
            j_q      <= '0;
            wa_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            nin_q    <= nin_d;
            nn_q     <= nn_d;
            stride_q <= stride_d;
            i_q      <= i_d;
            j_q      <= j_d;
            wa_q     <= wa_d;
            cnt_q    <= cnt_d;
        end
    end

    // Output registers, so every strobe and address is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            acc_load_q <= 1'b0;
            mac_en_q   <= 1'b0;
            out_wr_q   <= 1'b0;
            b_addr_q   <= '0;
            w_addr_q   <= '0;
            x_addr_q   <= '0;
            out_addr_q <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            acc_load_q <= acc_load_d;
            mac_en_q   <= mac_en_d;
            out_wr_q   <= out_wr_d;
            b_addr_q   <= b_addr_d;
            w_addr_q   <= w_addr_d;
            x_addr_q   <= x_addr_d;
            out_addr_q <= out_addr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign acc_load = acc_load_q;
    assign mac_en   = mac_en_q;
    assign out_wr   = out_wr_q;
    assign b_addr   = b_addr_q;
    assign w_addr   = w_addr_q;
    assign x_addr   = x_addr_q;
    assign out_addr = out_addr_q;

`ifdef DENSE_SEQ_PERF_EN
    logic [15:0] perf_q;

    // Busy-cycle counter: cleared on accepted start, saturating, held when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            perf_q <= '0;
        end else if (busy_q && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 16'd0;
`endif

endmodule
